// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - op_length (funct3) encodings for loads and stores
//   - FSM state type for the bus transaction sequencer
package mem_pkg;

  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for 32-bit data accesses (purely combinational).
// Ports:
//   i_len    funct3 access length (B/H/W/BU/HU; other codes act as word)
//   i_off    byte offset within the word (already forced to alignment by the caller)
//   i_rs2    store data from the register file
//   i_rdata  word returned by the bus
//   o_strb   store byte enables
//   o_wdata  lane-replicated store data
//   o_load   extracted and extended load value
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_len,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = i_rdata >> {i_off, 3'b000};
    o_strb    = 4'b1111;
    o_wdata   = i_rs2;
    o_load    = w_shifted;
    case (i_len)
      LEN_B, LEN_BU: begin
        o_strb  = 4'b0001 << i_off;
        o_wdata = {4{i_rs2[7:0]}};
        o_load  = (i_len == LEN_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                   : {24'b0, w_shifted[7:0]};
      end
      LEN_H, LEN_HU: begin
        o_strb  = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_rs2[15:0]}};
        o_load  = (i_len == LEN_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                   : {16'b0, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Runs one valid/ready bus transaction per load or
// store, stalling the pipeline until the response, and registers the MEM/WB values.
// Non-memory instructions pass through to wb_* with one cycle of latency.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses issue no bus
// request and pulse misaligned_fault instead; without it, low address bits are
// forced to alignment and the access proceeds.
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   mem_*                          EX/MEM register outputs
//   stall                          holds EX/MEM and earlier stages
//   bus_req_*, bus_resp_*          data-memory request/response channels
//   wb_result, wb_rd, wb_reg_write MEM/WB register
//   misaligned_fault               (LSU_MISALIGN_TRAP_EN only) registered fault pulse
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       mem_alu_result,
  input  logic [DATA_W-1:0] mem_rs2_data,
  input  logic [4:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_write,
  input  logic              mem_mem_read,
  input  logic [2:0]        mem_mem_op_length,
  output logic              stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [3:0]        bus_req_strb,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_rdata,
  output logic [DATA_W-1:0] wb_result,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misaligned_fault
`endif
);

  lsu_state_t r_state, w_state_next;

  logic [2:0]  r_len;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;
  logic        r_reg_write;

  logic        w_mem_op, w_misaligned, w_issue, w_pass, w_done;
  logic [1:0]  w_off_raw, w_eff_off, w_al_off;
  logic [2:0]  w_al_len;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata, w_load;

  assign w_mem_op  = mem_mem_read | mem_mem_write;
  assign w_off_raw = mem_alu_result[1:0];

  // len[1:0]: 00 byte, 01 half, 1x word (includes the undefined codes).
  always_comb begin
    w_eff_off = 2'b00;
    if (mem_mem_op_length[1:0] == 2'b00)      w_eff_off = w_off_raw;
    else if (mem_mem_op_length[1:0] == 2'b01) w_eff_off = {w_off_raw[1], 1'b0};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = w_mem_op & (w_eff_off != w_off_raw);
`else
  assign w_misaligned = 1'b0;
`endif

  // One aligner serves both directions: store lanes from EX/MEM while idle,
  // load extraction from the captured request while waiting for the response.
  assign w_al_len = (r_state == IDLE) ? mem_mem_op_length : r_len;
  assign w_al_off = (r_state == IDLE) ? w_eff_off : r_off;

  lsu_align u_align (
    .i_len   (w_al_len),
    .i_off   (w_al_off),
    .i_rs2   (mem_rs2_data),
    .i_rdata (bus_resp_rdata),
    .o_strb  (w_strb),
    .o_wdata (w_wdata),
    .o_load  (w_load)
  );

  assign bus_req_valid = (r_state == REQ);

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    w_issue      = 1'b0;
    w_pass       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_mem_op) begin
          w_pass = 1'b1;
        end else if (!w_misaligned) begin
          stall        = 1'b1;
          w_issue      = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_req_ready) w_state_next = RESP;
      end
      RESP: begin
        if (bus_resp_valid) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_len         <= 3'b000;
      r_off         <= 2'b00;
      r_rd          <= 5'd0;
      r_reg_write   <= 1'b0;
      bus_req_write <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_strb  <= 4'b0000;
      wb_result     <= '0;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      // Bubble by default; only pass-through and completion write back.
      wb_reg_write <= 1'b0;
      if (w_issue) begin
        r_len         <= mem_mem_op_length;
        r_off         <= w_eff_off;
        r_rd          <= mem_rd;
        r_reg_write   <= mem_reg_write;
        bus_req_write <= mem_mem_write;
        bus_req_addr  <= {mem_alu_result[ADDR_W-1:2], 2'b00};
        bus_req_wdata <= w_wdata;
        bus_req_strb  <= mem_mem_write ? w_strb : 4'b0000;
      end
      if (w_pass) begin
        wb_result    <= mem_alu_result;
        wb_rd        <= mem_rd;
        wb_reg_write <= mem_reg_write;
      end
      if (w_done) begin
        // Store acks carry no data; keep the previous result.
        if (!bus_req_write) wb_result <= w_load;
        wb_rd        <= r_rd;
        wb_reg_write <= r_reg_write;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) misaligned_fault <= 1'b0;
    else          misaligned_fault <= (r_state == IDLE) & w_misaligned;
  end
`endif

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit.
- Consumes the EX/MEM register outputs, runs one data-memory transaction per load or store over a valid/ready bus, and stalls the pipeline until that transaction completes.
- Produces the registered MEM/WB values: result, rd and reg_write.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
- ADDR_W, 32, bus address width. Addresses are the low ADDR_W bits of mem_alu_result, word-aligned on the bus.
- DATA_W, 32, data width. Fixed at 32; any other value is unsupported.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, active low
- mem_alu_result  in  32  effective address, or ALU result for non-memory ops
- mem_rs2_data  in  32  store data
- mem_rd  in  5  destination register
- mem_reg_write  in  1  instruction writes rd
- mem_mem_write  in  1  store
- mem_mem_read  in  1  load
- mem_mem_op_length  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- stall  out  1  hold EX/MEM and earlier stages
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_write  out  1  1 = store
- bus_req_addr  out  ADDR_W  word address, bits [1:0] = 0
- bus_req_wdata  out  32  lane-replicated store data
- bus_req_strb  out  4  byte enables; 0000 on reads
- bus_resp_valid  in  1  response valid, single-cycle pulse
- bus_resp_rdata  in  32  read word
- wb_result  out  32  MEM/WB result
- wb_rd  out  5  MEM/WB rd
- wb_reg_write  out  1  MEM/WB write enable
- misaligned_fault  out  1  one-cycle pulse; exists only with the optional feature

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset is asynchronous and active low. Assertion mid-transaction returns to IDLE and drops bus_req_valid immediately. A late bus_resp_valid arriving in IDLE is ignored.
- FSM states:
  - IDLE: if mem_mem_read or mem_mem_write, register bus request fields and go to REQ. Otherwise capture the pass-through values into wb_*.
  - REQ: bus_req_valid=1. Request fields are held stable until bus_req_ready. On bus_req_ready go to RESP. Valid may not be withdrawn before ready.
  - RESP: wait for bus_resp_valid. On the response, capture wb_* and go to IDLE. Stores also wait for the response (ack); rdata is ignored for stores.
  - bus_req_ready and bus_resp_valid in the same cycle in REQ is illegal; the bus guarantees this never occurs.
- stall: high (combinationally) in IDLE when a memory op is present, in REQ, and in RESP without bus_resp_valid. Low in the completion cycle, so the next op arrives on the following edge.
- While stall is high, wb_reg_write <= 0 (bubble); wb_result and wb_rd hold.
- Pass-through timing: wb_result <= mem_alu_result, wb_rd <= mem_rd, wb_reg_write <= mem_reg_write, one cycle later.
- Minimum memory-op latency: 3 cycles, with ready and response each arriving in the first cycle they can.
- Lane rules, with off = addr[1:0]:
  - SB: strb = 0001<<off; wdata = rs2[7:0] replicated x4.
  - SH: strb = 0011<<(2*off[1]); wdata = rs2[15:0] replicated x2.
  - SW: strb = 1111.
- Load extraction: shift rdata right by 8*off, then:
  - B: sign-extend bit 7.
  - BU: zero-extend.
  - H: sign-extend bit 15.
  - HU: zero-extend.
  - W: unchanged.
- Undefined op_length codes (011, 110, 111) are treated as word.
- If read and write are both set, write wins.
- A load with mem_reg_write=0 still performs the bus access; wb_reg_write=0 for it.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with off[0]=1, or a word with off!=00, issues no bus request.
  - misaligned_fault pulses for 1 cycle, registered.
  - wb_reg_write <= 0.
  - No stall.
  - The port exists.
- Undefined:
  - Misaligned addresses have their low bits forced to alignment: H clears bit 0; W clears bits 1:0.
  - The access proceeds normally.
  - The misaligned_fault port is absent.

Decomposition:
- Package mem_pkg: op_length encoding constants (LEN_B, LEN_H, LEN_W, LEN_BU, LEN_HU) and the FSM state enum (IDLE, REQ, RESP).
- Sub-module lsu_align: purely combinational. Computes strb and wdata from op_length, off and rs2, and computes load extraction from op_length, off and rdata. Shared with any future fetch/uncached path.

Test Plan:
- ALU op with alu_result=0x1234, rd=5, reg_write=1 -> next edge wb_result=0x1234, wb_rd=5, wb_reg_write=1, stall never high.
- SB at addr 0x103, rs2=0xAABBCCDD -> bus_req_addr=0x100, strb=1000, wdata=0xDDDDDDDD, write=1. stall high until the response cycle; wb_reg_write=0.
- LB at 0x102, rdata=0x00800000 -> wb_result=0xFFFFFF80. LBU, same inputs -> 0x00000080. LHU at 0x102, rdata=0xBEEF0000 -> 0x0000BEEF.
- LW with bus_req_ready held low 4 cycles, then response after 2 more -> req fields stable throughout, stall high every cycle until the response, wb captured on the response edge.
- reset_n low while in RESP, then a bus_resp_valid pulse after release -> state IDLE, outputs 0, pulse ignored, no wb write.
- LW at 0x101: with LSU_MISALIGN_TRAP_EN -> no req, misaligned_fault=1 for one cycle, wb_reg_write=0. Without it -> bus_req_addr=0x100, normal load.
